riscv_multicycle_ctrl: RTL and testbench
========================================

# riscv_multicycle_ctrl

Multi-cycle control unit that sequences the RV32I datapath one instruction at a time. It fetches through an instruction-memory request/ready handshake, holds the instruction in an internal register, decodes it into the datapath's mux, ALU and extend controls, and steps through execute, memory and write-back states. It drives the datapath's program-counter enable and register-file write enable, so each instruction takes 3–5 cycles with zero-wait memories.

## Interface
- Parameters: none.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `imem_req` out 1: instruction fetch request.
- `imem_ready` in 1: fetch data valid.
- `imem_rdata` in 32: fetched instruction.
- `machineCode` out 32: instruction register, drives the datapath.
- `pcEn` out 1: program-counter load enable.
- `regFile_wr_en` out 1: register-file write enable.
- `ALUControl` out 4: ALU operation.
- `extType` out 3: immediate format.
- `AluSrcMuxSel` out 1: 0 = rs2, 1 = immediate.
- `RFWriteDataSrcMuxSel` out 2: write-back source.
- `Bbranch`, `Jbranch`, `JIbranch` out 1 each: branch, JAL/JALR, JALR.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: data memory write.
- `dmem_ready` in 1: data access complete.
- `illegal` out 1: sticky illegal-opcode flag.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- Reset enters IDLE. IDLE always moves to FETCH on the next cycle.
- **FETCH**
  - `imem_req`=1.
  - Stays in FETCH while `imem_ready`=0.
  - On `imem_ready`=1, latches `imem_rdata` into `machineCode` and moves to DECODE.
- **DECODE**
  - Registers all datapath controls from `machineCode`; they stay stable until the next DECODE.
  - Moves to EXECUTE, or to TRAP for an illegal opcode.
- **Opcode decode** (extType / AluSrcMuxSel / RFWriteDataSrcMuxSel):
  - R 0110011: —/0/00.
  - I 0010011: 000/1/00.
  - L 0000011: 000/1/01.
  - S 0100011: 001/1/—.
  - B 1100011: 010/0/—, `Bbranch`=1.
  - LUI 0110111: 011/—/10.
  - AUIPC 0010111: 011/—/11.
  - JAL 1101111: 100/—/11, `Jbranch`=1.
  - JALR 1100111: 000/1/11, `Jbranch`=1, `JIbranch`=1.
  - Don't-care fields drive 0.
- **ALUControl = {f7b, funct3}**
  - f7b = `machineCode[30]` for R-type and for I-type funct3=101; 0 otherwise.
  - Encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - B-type: `{1'b0, funct3}`.
  - L, S, JALR: ADD.
- **EXECUTE**
  - B: `pcEn`=1, then FETCH.
  - L, S: go to MEM.
  - All others: go to WB.
- **MEM**
  - `dmem_req`=1; `dmem_we`=1 for S.
  - Held until `dmem_ready`=1.
  - Then L goes to WB; S asserts `pcEn`=1 and goes to FETCH.
- **WB**: `regFile_wr_en`=1 and `pcEn`=1 for one cycle, then FETCH.
- **TRAP**: all enables 0, `illegal`=1. Exits only by reset.
- `pcEn`, `regFile_wr_en`, `imem_req`, `dmem_req` and `dmem_we` decode directly from the current state (Moore outputs).
- Each instruction asserts `pcEn` exactly once and `regFile_wr_en` at most once.

## Timing
- Reset asserted: state IDLE, `machineCode`=0, all controls and enables 0, `illegal`=0. This applies immediately, mid-instruction included.
- Cycle counts with zero-wait memories (ready=1 in the first request cycle):
  - B: 3.
  - R, I, LUI, AUIPC, JAL, JALR, S: 4.
  - L: 5.
- Each wait cycle on `imem_ready` or `dmem_ready` adds one cycle.
- `imem_ready` is ignored outside FETCH; `dmem_ready` is ignored outside MEM.
- A ready pulse in the same cycle a request first asserts completes that request.
- `machineCode` changes only on the FETCH→DECODE edge.
- Branch outcome comes from the datapath comparator. The PC update happens at the `pcEn` edge in EXECUTE.

## Configuration
- `MCU_TRAP_EN` defined: illegal opcodes enter TRAP and set `illegal`.
- `MCU_TRAP_EN` undefined:
  - An illegal opcode executes as a NOP: DECODE→EXECUTE→FETCH with `pcEn`=1 in EXECUTE and no register write.
  - `illegal` ties to 0 and the TRAP state is removed.

## Test plan
- R-type `add x3,x1,x2` (0x002081B3), zero-wait memory → `ALUControl`=0000, `AluSrcMuxSel`=0; `regFile_wr_en` and `pcEn` high only in cycle 4; next `imem_req` in cycle 5.
- `lw x5,8(x0)` with `dmem_ready` delayed 3 cycles → `dmem_req` high 4 cycles with `dmem_we`=0, `RFWriteDataSrcMuxSel`=01; WB follows.
- `sw` → `dmem_we`=1 during MEM; `pcEn` on the `dmem_ready` cycle; `regFile_wr_en` never asserted.
- `beq` (0x00208463) → `Bbranch`=1, `extType`=010, `ALUControl`=0000; `pcEn` in cycle 3; `regFile_wr_en`=0.
- `jalr x1,0(x2)` → `Jbranch`=`JIbranch`=1, `RFWriteDataSrcMuxSel`=11; then `reset` low mid-MEM of a following load → immediate IDLE and all outputs 0.
- Opcode 0x0000007F with `MCU_TRAP_EN` → `illegal`=1 and no further `imem_req`. Without the macro → `pcEn` pulse in cycle 3, then the next fetch.

Source files
------------

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: multi-cycle RV32I control FSM (fetch/decode/execute/mem/wb).
// Define MCU_TRAP_EN to trap illegal opcodes; otherwise they retire as NOPs.
module riscv_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] machineCode,
  output logic        pcEn,
  output logic        regFile_wr_en,
  output logic [3:0]  ALUControl,
  output logic [2:0]  extType,
  output logic        AluSrcMuxSel,
  output logic [1:0]  RFWriteDataSrcMuxSel,
  output logic        Bbranch,
  output logic        Jbranch,
  output logic        JIbranch,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        illegal
);
`ifdef MCU_TRAP_EN
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WB} state_t;
`endif
  state_t state, next;
  logic [6:0] op;
  logic [2:0] f3;
  logic is_r, is_i, is_l, is_s, is_b, is_lui, is_auipc, is_jal, is_jalr, is_ill;
  logic [3:0] alu_d;
  logic [2:0] ext_d;
  logic [1:0] wd_d;
  assign op       = machineCode[6:0];
  assign f3       = machineCode[14:12];
  assign is_r     = op == 7'b0110011;
  assign is_i     = op == 7'b0010011;
  assign is_l     = op == 7'b0000011;
  assign is_s     = op == 7'b0100011;
  assign is_b     = op == 7'b1100011;
  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_ill   = !(is_r || is_i || is_l || is_s || is_b || is_lui || is_auipc || is_jal || is_jalr);
  // f7b only distinguishes SUB/SRA (R) and SRAI (I, funct3=101)
  assign alu_d = is_r ? {machineCode[30], f3} :
                 is_i ? {f3 == 3'b101 && machineCode[30], f3} :
                 is_b ? {1'b0, f3} : 4'b0000;
  assign ext_d = is_s ? 3'b001 : is_b ? 3'b010 : (is_lui || is_auipc) ? 3'b011 : is_jal ? 3'b100 : 3'b000;
  assign wd_d  = is_l ? 2'b01 : is_lui ? 2'b10 : (is_auipc || is_jal || is_jalr) ? 2'b11 : 2'b00;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = FETCH;
      FETCH:   next = imem_ready ? DECODE : FETCH;
`ifdef MCU_TRAP_EN
      DECODE:  next = is_ill ? TRAP : EXECUTE;
      TRAP:    next = TRAP;
`else
      DECODE:  next = EXECUTE;
`endif
      EXECUTE: next = (is_b || is_ill) ? FETCH : (is_l || is_s) ? MEM : WB;
      MEM:     next = !dmem_ready ? MEM : is_l ? WB : FETCH;
      WB:      next = FETCH;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    imem_req      = state == FETCH;
    dmem_req      = state == MEM;
    dmem_we       = state == MEM && is_s;
    regFile_wr_en = state == WB;
    pcEn          = state == WB || (state == EXECUTE && (is_b || is_ill)) ||
                    (state == MEM && is_s && dmem_ready);
  end
`ifdef MCU_TRAP_EN
  assign illegal = state == TRAP;
`else
  assign illegal = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      machineCode          <= '0;
      ALUControl           <= '0;
      extType              <= '0;
      AluSrcMuxSel         <= 1'b0;
      RFWriteDataSrcMuxSel <= '0;
      Bbranch              <= 1'b0;
      Jbranch              <= 1'b0;
      JIbranch             <= 1'b0;
    end else begin
      if (state == FETCH && imem_ready) machineCode <= imem_rdata;
      if (state == DECODE) begin
        ALUControl           <= alu_d;
        extType              <= ext_d;
        AluSrcMuxSel         <= is_i || is_l || is_s || is_jalr;
        RFWriteDataSrcMuxSel <= wd_d;
        Bbranch              <= is_b;
        Jbranch              <= is_jal || is_jalr;
        JIbranch             <= is_jalr;
      end
    end
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl: directed instructions feed a scoreboard checked at every pcEn retire.
module tb_riscv_multicycle_ctrl;
  logic clk = 1'b0, reset = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic imem_req, pcEn, regFile_wr_en, AluSrcMuxSel, Bbranch, Jbranch, JIbranch;
  logic dmem_req, dmem_we, illegal;
  logic [31:0] machineCode;
  logic [3:0] ALUControl;
  logic [2:0] extType;
  logic [1:0] RFWriteDataSrcMuxSel;
  always #5 clk = ~clk;
  riscv_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .machineCode(machineCode), .pcEn(pcEn),
    .regFile_wr_en(regFile_wr_en), .ALUControl(ALUControl), .extType(extType),
    .AluSrcMuxSel(AluSrcMuxSel), .RFWriteDataSrcMuxSel(RFWriteDataSrcMuxSel),
    .Bbranch(Bbranch), .Jbranch(Jbranch), .JIbranch(JIbranch),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .illegal(illegal)
  );
  typedef struct {
    logic [31:0] mc;
    logic [3:0] alu;
    logic [2:0] ext;
    logic src;
    logic [1:0] wd;
    logic b, j, ji, dwe;
    int cyc, wr, dreq;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endfunction
  function automatic exp_t mk(int cyc, logic [3:0] alu, logic [2:0] ext, logic src, logic [1:0] wd,
                              logic b, logic j, logic ji, int wr, int dreq, logic dwe);
    exp_t e;
    e.mc = '0; e.alu = alu; e.ext = ext; e.src = src; e.wd = wd;
    e.b = b; e.j = j; e.ji = ji; e.cyc = cyc; e.wr = wr; e.dreq = dreq; e.dwe = dwe;
    return e;
  endfunction
  initial begin
    int cyc, wr, dreq;
    logic dwe, prev;
    exp_t e;
    cyc = 0; wr = 0; dreq = 0; dwe = 1'b0; prev = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (imem_req && !prev) begin cyc = 0; wr = 0; dreq = 0; dwe = 1'b0; end
      prev = imem_req;
      cyc++;
      wr += int'(regFile_wr_en);
      dreq += int'(dmem_req);
      dwe |= dmem_we;
      if (pcEn) begin
        chk("pcEn_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("machineCode", machineCode, e.mc);
          chk("cycles", cyc, e.cyc);
          chk("ALUControl", ALUControl, e.alu);
          chk("extType", extType, e.ext);
          chk("AluSrcMuxSel", AluSrcMuxSel, e.src);
          chk("RFWriteDataSrcMuxSel", RFWriteDataSrcMuxSel, e.wd);
          chk("branch_flags", {Bbranch, Jbranch, JIbranch}, {e.b, e.j, e.ji});
          chk("regfile_writes", wr, e.wr);
          chk("dmem_req_cycles", dreq, e.dreq);
          chk("dmem_we_seen", dwe, e.dwe);
        end
      end
    end
  end
  task automatic wait_imem();
    for (int n = 0; n < 50 && !imem_req; n++) @(negedge clk);
    chk("imem_req_wait", imem_req, 1);
  endtask
  task automatic wait_dmem();
    for (int n = 0; n < 50 && !dmem_req; n++) @(negedge clk);
    chk("dmem_req_wait", dmem_req, 1);
  endtask
  task automatic run(input logic [31:0] code, input int iw, input int dw, input exp_t e);
    e.mc = code;
    q.push_back(e);
    wait_imem();
    repeat (iw) @(negedge clk);
    imem_rdata = code; imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0; imem_rdata = 32'hdeadbeef;
    if (e.dreq > 0) begin
      wait_dmem();
      imem_ready = 1'b1;  // stray fetch-ready while in MEM must not reload the IR
      repeat (dw) @(negedge clk);
      imem_ready = 1'b0; dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
    end
  endtask
  task automatic check_idle(input string name);
    chk(name, {machineCode, imem_req, pcEn, regFile_wr_en, ALUControl, extType, AluSrcMuxSel,
               RFWriteDataSrcMuxSel, Bbranch, Jbranch, JIbranch, dmem_req, dmem_we, illegal}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int seen;
    repeat (2) @(negedge clk); #1;
    check_idle("reset_state");
    @(negedge clk); reset = 1'b1;
    run(32'h002081B3, 0, 0, mk(4, 4'b0000, 3'b000, 0, 2'b00, 0, 0, 0, 1, 0, 0));
    run(32'h00802283, 0, 3, mk(8, 4'b0000, 3'b000, 1, 2'b01, 0, 0, 0, 1, 4, 0));
    run(32'h00502623, 0, 1, mk(5, 4'b0000, 3'b001, 1, 2'b00, 0, 0, 0, 0, 2, 1));
    run(32'h00208463, 0, 0, mk(3, 4'b0000, 3'b010, 0, 2'b00, 1, 0, 0, 0, 0, 0));
    run(32'h000100E7, 0, 0, mk(4, 4'b0000, 3'b000, 1, 2'b11, 0, 1, 1, 1, 0, 0));
    wait_imem();
    imem_rdata = 32'h00802283; imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    wait_dmem();
    @(negedge clk);
    reset = 1'b0; #1;
    check_idle("reset_mid_mem");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run(32'h40315093, 2, 0, mk(6, 4'b1101, 3'b000, 1, 2'b00, 0, 0, 0, 1, 0, 0));
    run(32'h40000093, 0, 0, mk(4, 4'b0000, 3'b000, 1, 2'b00, 0, 0, 0, 1, 0, 0));
    run(32'h402081B3, 0, 0, mk(4, 4'b1000, 3'b000, 0, 2'b00, 0, 0, 0, 1, 0, 0));
    run(32'h0020B1B3, 0, 0, mk(4, 4'b0011, 3'b000, 0, 2'b00, 0, 0, 0, 1, 0, 0));
    run(32'h123452B7, 0, 0, mk(4, 4'b0000, 3'b011, 0, 2'b10, 0, 0, 0, 1, 0, 0));
    run(32'h00001297, 0, 0, mk(4, 4'b0000, 3'b011, 0, 2'b11, 0, 0, 0, 1, 0, 0));
    run(32'h008000EF, 0, 0, mk(4, 4'b0000, 3'b100, 0, 2'b11, 0, 1, 0, 1, 0, 0));
`ifdef MCU_TRAP_EN
    wait_imem();
    imem_rdata = 32'h0000007F; imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    seen = 0;
    repeat (20) begin @(negedge clk); #1; seen += int'(imem_req); end
    chk("trap_illegal", illegal, 1);
    chk("trap_no_fetch", seen, 0);
`else
    run(32'h0000007F, 0, 0, mk(3, 4'b0000, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    run(32'h002081B3, 0, 0, mk(4, 4'b0000, 3'b000, 0, 2'b00, 0, 0, 0, 1, 0, 0));
    seen = 0;
    chk("illegal_tied_low", illegal, seen);
`endif
    repeat (6) @(negedge clk); #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
